// File: rtl/e203_ifu_ialign_pkg.sv
// Shared widths, state encoding and RVC detection for the IFU instruction realigner.
package e203_ifu_ialign_pkg;

  localparam int E203_PC_SIZE    = 32;
  localparam int E203_INSTR_SIZE = 32;
  localparam int E203_HALF_SIZE  = 16;

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ODD   = 2'd2
  } ialign_state_e;

  // A halfword whose low two bits are not 2'b11 is a complete compressed instruction.
  function automatic logic is_rvc(input logic [E203_HALF_SIZE-1:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/e203_ifu_ialign_sel.sv
// Combinational instruction select: builds the aligned instruction from the held half
// and the current fetch word, and reports how the state advances on a handshake.
module e203_ifu_ialign_sel
  import e203_ifu_ialign_pkg::*;
(
  input  logic [1:0]  i_state,
  input  logic [15:0] i_hold_half,
  input  logic        i_hold_err,
  input  logic [31:0] i_data,
  input  logic        i_rsp_err,
  output logic [31:0] o_instr,
  output logic        o_err,
  output logic        o_rv32,
  output logic        o_need_word,
  output logic        o_load_u,
  output logic [2:0]  o_adv
);

  logic [15:0] w_lo;
  assign w_lo = i_data[15:0];

  // o_load_u means the upper half of the fetch word becomes the new held half,
  // which is also exactly the condition for the next state being HOLD.
  always_comb begin
    o_instr     = '0;
    o_err       = 1'b0;
    o_need_word = 1'b1;
    o_load_u    = 1'b0;
    o_adv       = 3'd0;
    case (i_state)
      ST_ALIGN: begin
        o_err = i_rsp_err;
        if (is_rvc(w_lo)) begin
          o_instr  = {16'b0, w_lo};
          o_adv    = 3'd2;
          o_load_u = 1'b1;
        end else begin
          o_instr = i_data;
          o_adv   = 3'd4;
        end
      end
      ST_HOLD: begin
        if (is_rvc(i_hold_half)) begin
          o_instr     = {16'b0, i_hold_half};
          o_err       = i_hold_err;
          o_need_word = 1'b0;
          o_adv       = 3'd2;
        end else begin
          o_instr  = {w_lo, i_hold_half};
          o_err    = i_hold_err | i_rsp_err;
          o_adv    = 3'd4;
          o_load_u = 1'b1;
        end
      end
      ST_ODD: begin
        o_load_u = 1'b1;
      end
      default: begin
        o_need_word = 1'b0;
      end
    endcase
  end

  assign o_rv32 = (o_instr[1:0] == 2'b11);

endmodule

// File: rtl/e203_ifu_ialign.sv
// IFU instruction realigner: turns word-aligned fetch words into one whole RV32/RVC
// instruction per IR handshake, tracking the PC and a held upper halfword.
module e203_ifu_ialign
  import e203_ifu_ialign_pkg::*;
#(
  parameter int                 PC_SIZE    = E203_PC_SIZE,
  parameter int                 INSTR_SIZE = E203_INSTR_SIZE,
  parameter logic [PC_SIZE-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [PC_SIZE-1:0]    flush_pc,
  input  logic                  ifetch_rsp_valid,
  output logic                  ifetch_rsp_ready,
  input  logic [31:0]           ifetch_rsp_data,
  input  logic                  ifetch_rsp_err,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [INSTR_SIZE-1:0] ir_instr,
  output logic [PC_SIZE-1:0]    ir_pc,
  output logic                  ir_rv32,
  output logic                  ir_err
);

  ialign_state_e      r_state, w_state_next;
  logic [PC_SIZE-1:0] r_pc, w_pc_next;
  logic [15:0]        r_hold_half, w_hold_half_next;
  logic               r_hold_err, w_hold_err_next;

  logic [31:0] w_sel_instr;
  logic        w_sel_err, w_sel_rv32, w_need_word, w_load_u;
  logic [2:0]  w_adv;
  logic        w_active, w_odd, w_ir_valid, w_rsp_ready, w_step;

  e203_ifu_ialign_sel u_sel (
    .i_state     (r_state),
    .i_hold_half (r_hold_half),
    .i_hold_err  (r_hold_err),
    .i_data      (ifetch_rsp_data),
    .i_rsp_err   (ifetch_rsp_err),
    .o_instr     (w_sel_instr),
    .o_err       (w_sel_err),
    .o_rv32      (w_sel_rv32),
    .o_need_word (w_need_word),
    .o_load_u    (w_load_u),
    .o_adv       (w_adv)
  );

  assign w_active = !rst && !flush;
  assign w_odd    = (r_state == ST_ODD);

  // A word is only ever accepted in the cycle it is consumed: with the IR handshake,
  // or unconditionally in ODD where its lower half is dropped.
  assign w_ir_valid  = w_active && !w_odd && (w_need_word ? ifetch_rsp_valid : 1'b1);
  assign w_rsp_ready = w_active && w_need_word && (w_odd || ir_ready);
  assign w_step      = w_odd ? (ifetch_rsp_valid && w_rsp_ready) : (w_ir_valid && ir_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ALIGN;
      r_pc        <= RESET_PC;
      r_hold_half <= '0;
      r_hold_err  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_hold_half <= w_hold_half_next;
      r_hold_err  <= w_hold_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_hold_half_next = r_hold_half;
    w_hold_err_next  = r_hold_err;
    if (flush) begin
      w_pc_next       = flush_pc & {{(PC_SIZE-1){1'b1}}, 1'b0};
      w_state_next    = flush_pc[1] ? ST_ODD : ST_ALIGN;
      w_hold_err_next = 1'b0;
    end else if (w_step) begin
      w_pc_next    = r_pc + PC_SIZE'(w_adv);
      w_state_next = w_load_u ? ST_HOLD : ST_ALIGN;
      if (w_load_u) begin
        w_hold_half_next = ifetch_rsp_data[31:16];
        w_hold_err_next  = ifetch_rsp_err;
      end
    end
  end

  assign ir_valid         = w_ir_valid;
  assign ifetch_rsp_ready = w_rsp_ready;
  assign ir_instr         = rst ? '0 : INSTR_SIZE'(w_sel_instr);
  assign ir_pc            = rst ? RESET_PC : r_pc;
  assign ir_rv32          = rst ? 1'b0 : w_sel_rv32;
  assign ir_err           = rst ? 1'b0 : w_sel_err;

endmodule

// File: tb/tb_e203_ifu_ialign.sv
// Scoreboard bench for the IFU realigner: a halfword-level program model predicts the
// instruction stream; a monitor checks every IR handshake against it.
`timescale 1ns/1ps
module tb_e203_ifu_ialign;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          SEG_BUDGET = 400;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] flush_pc;
  logic        ifetch_rsp_valid, ifetch_rsp_ready;
  logic [31:0] ifetch_rsp_data;
  logic        ifetch_rsp_err;
  logic        ir_valid, ir_ready;
  logic [31:0] ir_instr, ir_pc;
  logic        ir_rv32, ir_err;

  e203_ifu_ialign #(.PC_SIZE(32), .INSTR_SIZE(32), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .ifetch_rsp_valid (ifetch_rsp_valid),
    .ifetch_rsp_ready (ifetch_rsp_ready),
    .ifetch_rsp_data  (ifetch_rsp_data),
    .ifetch_rsp_err   (ifetch_rsp_err),
    .ir_valid         (ir_valid),
    .ir_ready         (ir_ready),
    .ir_instr         (ir_instr),
    .ir_pc            (ir_pc),
    .ir_rv32          (ir_rv32),
    .ir_err           (ir_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rv32;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mem_w[$];
  logic        mem_e[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_delivered = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // Monitor: every IR handshake must match the head of the expected stream.
  always @(negedge clk) begin
    if (!rst && ir_valid && ir_ready) begin
      n_delivered++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_ir: got pc=%h instr=%h, want no instruction", ir_pc, ir_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ir_instr, ir_pc, ir_rv32, ir_err} === {mon_e.instr, mon_e.pc, mon_e.rv32, mon_e.err}) begin
          n_pass++;
          $display("ir  pc=%h instr=%h rv32=%0d err=%0d ok", ir_pc, ir_instr, ir_rv32, ir_err);
        end else begin
          $display("FAIL ir_txn: got pc=%h instr=%h rv32=%0d err=%0d, want pc=%h instr=%h rv32=%0d err=%0d",
                   ir_pc, ir_instr, ir_rv32, ir_err, mon_e.pc, mon_e.instr, mon_e.rv32, mon_e.err);
        end
      end
    end
  end

  function automatic logic [15:0] half_at(input int i);
    logic [31:0] w;
    w = mem_w[i / 2];
    return (i % 2 == 1) ? w[31:16] : w[15:0];
  endfunction

  // Reference model: walk the program halfword by halfword from the start PC and emit
  // every instruction that lies entirely inside the supplied words.
  task automatic push_expected(input logic [31:0] start_pc);
    logic [31:0] base;
    int          nh;
    int          i;
    exp_t        e;
    base = {start_pc[31:2], 2'b00};
    nh   = 2 * mem_w.size();
    i    = int'(start_pc[1]);
    while (i < nh) begin
      e.pc = base + 32'(2 * i);
      if (half_at(i) % 4 != 3) begin
        e.instr = {16'h0, half_at(i)};
        e.rv32  = 1'b0;
        e.err   = mem_e[i / 2];
        i += 1;
      end else if (i + 1 < nh) begin
        e.instr = {half_at(i + 1), half_at(i)};
        e.rv32  = 1'b1;
        e.err   = mem_e[i / 2] | mem_e[(i + 1) / 2];
        i += 2;
      end else begin
        break;
      end
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1) == 1) h[1:0] = 2'b11;
    else h[1:0] = 2'($urandom_range(2));
    return h;
  endfunction

  task automatic rand_mem(input int n);
    mem_w.delete();
    mem_e.delete();
    for (int k = 0; k < n; k++) begin
      mem_w.push_back({rand_half(), rand_half()});
      mem_e.push_back($urandom_range(7) == 0);
    end
  endtask

  // Entered and left at posedge+1. Optionally redirects, then streams mem_w with random
  // gaps and IR backpressure; abort_after>=0 stops after that many deliveries.
  task automatic drive_segment(input logic do_flush, input logic [31:0] fpc, input int abort_after);
    int   idx, cycles, target;
    logic presenting;
    if (do_flush) begin
      flush            = 1'b1;
      flush_pc         = fpc;
      exp_q.delete();
      ifetch_rsp_valid = 1'b1;
      ifetch_rsp_data  = $urandom;
      ifetch_rsp_err   = 1'b0;
      ir_ready         = 1'b1;
      @(negedge clk);
      check("flush_ir_valid", 64'(ir_valid), 64'd0);
      check("flush_rsp_ready", 64'(ifetch_rsp_ready), 64'd0);
      @(posedge clk); #1;
      flush            = 1'b0;
      ifetch_rsp_valid = 1'b0;
      push_expected({fpc[31:1], 1'b0});
    end else begin
      push_expected(RESET_PC);
    end
    idx = 0;
    cycles = 0;
    presenting = 1'b0;
    target = n_delivered + abort_after;
    while ((idx < mem_w.size() || exp_q.size() != 0) && cycles < SEG_BUDGET) begin
      if (abort_after >= 0 && n_delivered >= target) break;
      if (!presenting && idx < mem_w.size() && $urandom_range(3) != 0) presenting = 1'b1;
      ifetch_rsp_valid = presenting;
      ifetch_rsp_data  = presenting ? mem_w[idx] : $urandom;
      ifetch_rsp_err   = presenting ? mem_e[idx] : 1'b0;
      ir_ready         = ($urandom_range(3) != 0);
      @(negedge clk);
      if (ifetch_rsp_valid && ifetch_rsp_ready) begin
        idx++;
        presenting = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    if (abort_after < 0) begin
      ifetch_rsp_valid = 1'b0;
      ir_ready         = 1'b1;
      check("segment_done_in_budget", 64'(cycles < SEG_BUDGET), 64'd1);
      @(negedge clk);
      check("idle_ir_valid", 64'(ir_valid), 64'd0);
      @(posedge clk); #1;
      ir_ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    flush            = 1'b0;
    flush_pc         = '0;
    ifetch_rsp_valid = 1'b1;
    ifetch_rsp_data  = 32'h0000_0013;
    ifetch_rsp_err   = 1'b1;
    ir_ready         = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ir_valid", 64'(ir_valid), 64'd0);
    check("rst_rsp_ready", 64'(ifetch_rsp_ready), 64'd0);
    check("rst_ir_instr", 64'(ir_instr), 64'd0);
    check("rst_ir_pc", 64'(ir_pc), 64'(RESET_PC));
    check("rst_ir_rv32", 64'(ir_rv32), 64'd0);
    check("rst_ir_err", 64'(ir_err), 64'd0);
    @(posedge clk); #1;
    rst              = 1'b0;
    ifetch_rsp_valid = 1'b0;
    ifetch_rsp_err   = 1'b0;
    ir_ready         = 1'b0;
    @(negedge clk);
    check("post_rst_ir_valid", 64'(ir_valid), 64'd0);
    check("post_rst_ir_pc", 64'(ir_pc), 64'(RESET_PC));
    @(posedge clk); #1;

    // addi after reset, then a second word at RESET_PC+4
    mem_w = '{32'h0000_0013, 32'h0010_0093};
    mem_e = '{1'b0, 1'b0};
    drive_segment(1'b0, RESET_PC, -1);

    // two RVC in one word
    mem_w = '{32'h4505_4501};
    mem_e = '{1'b0};
    drive_segment(1'b1, 32'h8000_0000, -1);

    // split 32-bit instruction across words
    mem_w = '{32'h0093_4501, 32'h4581_0000};
    mem_e = '{1'b0, 1'b0};
    drive_segment(1'b1, 32'h8000_0000, -1);

    // error on the second word of a split instruction carries into U
    mem_w = '{32'h0093_4501, 32'h4581_0000};
    mem_e = '{1'b0, 1'b1};
    drive_segment(1'b1, 32'h8000_1000, -1);

    // backpressure: instruction held stable for 3 cycles, then flushed away
    mem_w = '{32'h0000_0013};
    mem_e = '{1'b0};
    drive_segment(1'b1, 32'h8000_0200, 0);
    ifetch_rsp_valid = 1'b1;
    ifetch_rsp_data  = 32'h0000_0013;
    ifetch_rsp_err   = 1'b0;
    ir_ready         = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_ir_valid", 64'(ir_valid), 64'd1);
      check("bp_ir_instr", 64'(ir_instr), 64'h13);
      check("bp_ir_pc", 64'(ir_pc), 64'h8000_0200);
      check("bp_rsp_ready", 64'(ifetch_rsp_ready), 64'd0);
      @(posedge clk); #1;
    end

    // odd redirect (bit 0 of flush_pc ignored): lower half of the first word discarded
    mem_w = '{32'h0001_4581};
    mem_e = '{1'b0};
    drive_segment(1'b1, 32'h8000_0103, -1);

    // PC wraps past the top of the address space
    rand_mem(3);
    drive_segment(1'b1, 32'hFFFF_FFFE, -1);

    for (int s = 0; s < 40; s++) begin
      rand_mem(int'($urandom_range(1, 8)));
      drive_segment(1'b1, 32'h8000_0000 | 32'($urandom_range(0, 16'hFFFF)),
                    ($urandom_range(3) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/e203_ifu_ialign.md
Name: e203_ifu_ialign

Overview:
- Instruction realigner between the IFU fetch-response path and the IFU mini-decoder / IR stage.
- Takes word-aligned 32-bit fetch words and produces one whole RV32/RVC instruction per handshake, with its PC.
- Handles 16-bit instructions, 32-bit instructions split across two fetch words, and redirects to halfword-aligned targets.
- The IR-side `instr` is always a complete instruction; the decoder never sees a split or partial word.

Parameters:
- PC_SIZE, 32, width of PCs.
- INSTR_SIZE, 32, instruction and fetch-word width; fixed at 32.
- RESET_PC, 32'h8000_0000, PC of the first instruction after reset; bit 1 must be 0.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  redirect pulse; highest priority.
- flush_pc  in  PC_SIZE  redirect target; bit 0 ignored.
- ifetch_rsp_valid  in  1  fetch word valid.
- ifetch_rsp_ready  out  1  fetch word accepted when valid&ready.
- ifetch_rsp_data  in  32  word-aligned fetch data, little-endian halfwords.
- ifetch_rsp_err  in  1  bus/access error on this word.
- ir_valid  out  1  aligned instruction available.
- ir_ready  in  1  IR stage accepts.
- ir_instr  out  INSTR_SIZE  instruction; RVC instructions are zero-extended in [31:16].
- ir_pc  out  PC_SIZE  PC of ir_instr.
- ir_rv32  out  1  1 when ir_instr[1:0]==2'b11.
- ir_err  out  1  fetch error on any halfword of this instruction.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Registered state:
  - `state` ∈ {ALIGN, HOLD, ODD}.
  - `pc`: PC of the next instruction.
  - `hold_half`: 16 bits.
  - `hold_err`: 1 bit.
- Reset values:
  - state=ALIGN, pc=RESET_PC, hold_half=0, hold_err=0.
  - Outputs while rst is high: ir_valid=0, ifetch_rsp_ready=0, ir_instr=0, ir_pc=RESET_PC, ir_rv32=0, ir_err=0.
- Outputs are combinational from the registered state and the current fetch word. Latency is 0 cycles from the fetch word to ir_valid when no extra half is needed.
- Let L=data[15:0] and U=data[31:16]. "Half is 32-bit" means half[1:0]==2'b11.
- ALIGN state:
  - ir_valid = rsp_valid.
  - If L is 32-bit: ir_instr=data, err=rsp_err. On the IR handshake, consume the word, pc+=4, stay in ALIGN.
  - If L is 16-bit: ir_instr={16'b0,L}. On the IR handshake, consume the word, store U into hold_half, copy rsp_err into hold_err, pc+=2, go to HOLD.
- HOLD state, hold_half is 16-bit:
  - ir_valid=1 and ifetch_rsp_ready=0; no word is needed.
  - ir_instr={16'b0,hold_half}, err=hold_err.
  - On handshake: pc+=2, go to ALIGN.
- HOLD state, hold_half is 32-bit:
  - ir_valid=rsp_valid, ir_instr={L,hold_half}, err=hold_err|rsp_err.
  - On handshake: consume the word, hold_half=U, hold_err=rsp_err, pc+=4, stay in HOLD.
- ODD state (after a redirect to pc[1]=1):
  - ir_valid=0 and ifetch_rsp_ready=1.
  - On word accept: discard L, hold_half=U, hold_err=rsp_err, go to HOLD. pc is unchanged.
- Ready rule: ifetch_rsp_ready = ir_ready whenever the word is consumed by the IR handshake. A word is consumed exactly in the same cycle as its IR handshake (or on the ODD accept); it is never accepted without being consumed.
- Flush:
  - Overrides everything in its cycle: ir_valid=0 and ifetch_rsp_ready=0, so no handshake completes.
  - Next cycle: pc={flush_pc[PC_SIZE-1:1],1'b0}, state = flush_pc[1] ? ODD : ALIGN, hold_err=0. hold_half is don't-care.
  - The fetch unit guarantees that no pre-flush words arrive after a flush.
- Reset during an operation discards the held half; there is no drain.
- PC arithmetic is modulo 2^PC_SIZE and wraps silently.
- ir_valid must remain stable until ir_ready, unless a flush occurs. Since the output is combinational, this requires that rsp_valid and rsp_data are held stable by the fetch side (valid/ready rule).

Decomposition:
- Shared package (e203_defines): E203_PC_SIZE, E203_INSTR_SIZE, halfword width 16, ALIGN/HOLD/ODD state encodings (2-bit localparams), RVC-detect macro (half[1:0]!=2'b11).
- One sub-module is natural: e203_ifu_ialign_sel. It is a combinational mux that takes state, hold_half and data and produces instr, rv32 and the consume/advance amount (2 or 4).
- The sequential state, pc and hold logic stays in the top.

Test Plan:
- Reset: rst=1 then release, fetch word 0x0000_0013 (addi) -> ir_instr=0x00000013, ir_pc=0x80000000, ir_rv32=1; next pc 0x80000004.
- Two RVC in one word: word 0x4505_4501 at 0x80000000 -> ir_instr=0x00004501 @0x80000000, then 0x00004505 @0x80000002 with ifetch_rsp_ready=0; 1 word consumed, 2 instructions delivered.
- Split instruction: words 0x0093_4501, then 0x4581_0000 -> 0x00004501 @0x80000000, then 0x00000093 @0x80000002 (rv32=1), then 0x00004581 @0x80000006.
- Odd flush: flush with flush_pc=0x80000102, then word 0x0001_4581 -> no IR output for the first word, hold=0x0001, then 16-bit 0x00000001 @0x80000102.
- Error propagation: split instruction whose second word has rsp_err=1 -> ir_err=1 on the spanning instruction; hold_err=1 carries to the next instruction from U.
- Backpressure plus flush: ir_ready=0 for 3 cycles with stable ir_valid and ir_instr, then assert flush -> no handshake that cycle, pc=flush_pc, hold dropped.
